// File: rtl/zynq_tag_sequencer.sv
// Serial tag-bus sequencer: after reset it sends a reset packet to every client,
// then it accepts one request at a time and shifts it out LSB first, followed by a zero gap.
module zynq_tag_sequencer #(
  parameter int tag_els_p               = 16,
  parameter int tag_max_payload_width_p = 1,
  parameter int clk_div_p               = 1,
  parameter int gap_bits_p              = 2,
  localparam int lg_els   = (tag_els_p > 1) ? $clog2(tag_els_p) : 1,
  localparam int lg_width = (tag_max_payload_width_p > 0) ? $clog2(tag_max_payload_width_p + 1) : 1
) (
  input  logic                               clk_i,
  input  logic                               aresetn,
  input  logic                               v_i,
  output logic                               ready_o,
  input  logic [lg_els-1:0]                  node_id_i,
  input  logic                               data_not_reset_i,
  input  logic [lg_width-1:0]                len_i,
  input  logic [tag_max_payload_width_p-1:0] payload_i,
  output logic                               tag_data_o,
  output logic                               init_done_o,
  output logic                               busy_o
);

  localparam int max_a     = (lg_els > tag_max_payload_width_p) ? lg_els : tag_max_payload_width_p;
  localparam int max_field = (max_a > gap_bits_p) ? max_a : gap_bits_p;
  localparam int cnt_w     = $clog2(max_field + 1);
  localparam int div_w     = (clk_div_p > 1) ? $clog2(clk_div_p) : 1;
  localparam int frame_w   = 2 + lg_els + lg_width + tag_max_payload_width_p;

  localparam logic [lg_width-1:0] max_len   = lg_width'(tag_max_payload_width_p);
  localparam logic [lg_els-1:0]   last_node = lg_els'(tag_els_p - 1);
  localparam logic [div_w-1:0]    div_last  = div_w'(clk_div_p - 1);

  typedef enum logic [2:0] {INIT, IDLE, START, ID, DNR, LEN, PAYLOAD, GAP} state_t;

  state_t               state_reg, state_next;
  logic [div_w-1:0]     div_cnt_reg;
  logic [cnt_w-1:0]     bit_cnt_reg;
  logic [frame_w-1:0]   frame_reg;
  logic [lg_width-1:0]  len_reg;
  logic [lg_els-1:0]    node_reg;
  logic                 init_done_reg;

  logic [lg_width-1:0]  len_sat;
  logic [frame_w-1:0]   req_frame;
  logic [cnt_w-1:0]     field_len;
  logic                 bit_done;
  logic                 field_done;
  logic                 last_init;
  logic                 accept;
  logic                 shifting;

  // Whole packet is staged in one shift register: start bit in bit 0, payload on top.
  function automatic logic [frame_w-1:0] init_frame(input logic [lg_els-1:0] node);
    return {{tag_max_payload_width_p{1'b0}}, max_len, 1'b0, node, 1'b1};
  endfunction

  always_comb begin
    len_sat   = (len_i > max_len) ? max_len : len_i;
    req_frame = {payload_i, len_sat, data_not_reset_i, node_id_i, 1'b1};
    field_len = cnt_w'(1);
    case (state_reg)
      ID:      field_len = cnt_w'(lg_els);
      LEN:     field_len = cnt_w'(lg_width);
      PAYLOAD: field_len = cnt_w'(len_reg);
      GAP:     field_len = cnt_w'(gap_bits_p);
      default: field_len = cnt_w'(1);
    endcase
    bit_done   = (div_cnt_reg == div_last);
    field_done = bit_done && (bit_cnt_reg == field_len - 1'b1);
    last_init  = !init_done_reg && (node_reg == last_node);
    accept     = (state_reg == IDLE) && init_done_reg && v_i;
    shifting   = (state_reg == START) || (state_reg == ID) || (state_reg == DNR) ||
                 (state_reg == LEN) || (state_reg == PAYLOAD);
  end

  always_comb begin
    state_next  = state_reg;
    ready_o     = 1'b0;
    busy_o      = 1'b1;
    tag_data_o  = 1'b0;
    init_done_o = init_done_reg;
    case (state_reg)
      INIT: state_next = START;
      IDLE: begin
        busy_o  = 1'b0;
        ready_o = init_done_reg;
        if (accept) state_next = START;
      end
      START: begin
        tag_data_o = frame_reg[0];
        if (field_done) state_next = ID;
      end
      ID: begin
        tag_data_o = frame_reg[0];
        if (field_done) state_next = DNR;
      end
      DNR: begin
        tag_data_o = frame_reg[0];
        if (field_done) state_next = LEN;
      end
      LEN: begin
        tag_data_o = frame_reg[0];
        if (field_done) state_next = (len_reg == '0) ? GAP : PAYLOAD;
      end
      PAYLOAD: begin
        tag_data_o = frame_reg[0];
        if (field_done) state_next = GAP;
      end
      GAP: begin
        if (field_done) state_next = (init_done_reg || last_init) ? IDLE : START;
      end
      default: state_next = INIT;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!aresetn) begin
      state_reg     <= INIT;
      div_cnt_reg   <= '0;
      bit_cnt_reg   <= '0;
      frame_reg     <= '0;
      len_reg       <= max_len;
      node_reg      <= '0;
      init_done_reg <= 1'b0;
    end else begin
      state_reg <= state_next;

      if (state_reg == INIT || state_reg == IDLE || bit_done) div_cnt_reg <= '0;
      else                                                    div_cnt_reg <= div_cnt_reg + 1'b1;

      if (state_reg == INIT || state_reg == IDLE || field_done) bit_cnt_reg <= '0;
      else if (bit_done)                                        bit_cnt_reg <= bit_cnt_reg + 1'b1;

      if (state_reg == INIT) begin
        frame_reg <= init_frame(node_reg);
        len_reg   <= max_len;
      end else if (accept) begin
        frame_reg <= req_frame;
        len_reg   <= len_sat;
      end else if (shifting && bit_done) begin
        frame_reg <= {1'b0, frame_reg[frame_w-1:1]};
      end else if (state_reg == GAP && field_done && !init_done_reg && !last_init) begin
        // Next init packet starts straight out of the gap, no extra cycle through INIT.
        node_reg  <= node_reg + 1'b1;
        frame_reg <= init_frame(node_reg + 1'b1);
        len_reg   <= max_len;
      end

      if (state_reg == GAP && field_done && last_init) init_done_reg <= 1'b1;
    end
  end

endmodule

// File: tb/tb_zynq_tag_sequencer.sv
// Bench for zynq_tag_sequencer: init sweep at divide 1 and 3, directed and random
// requests, back-to-back streaming and mid-packet reset against a bit-level packet model.
module tb_zynq_tag_sequencer;

  localparam int LG_ELS = 4;

  logic       clk = 1'b0;
  logic       aresetn;
  logic       v_i;
  logic [3:0] node_id;
  logic       dnr;
  logic [0:0] len;
  logic [0:0] payload;
  logic       ready, tag, init_done, busy;
  logic       ready3, tag3, init_done3, busy3;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  zynq_tag_sequencer dut (
    .clk_i(clk), .aresetn(aresetn), .v_i(v_i), .ready_o(ready),
    .node_id_i(node_id), .data_not_reset_i(dnr), .len_i(len), .payload_i(payload),
    .tag_data_o(tag), .init_done_o(init_done), .busy_o(busy)
  );

  zynq_tag_sequencer #(.clk_div_p(3)) dut3 (
    .clk_i(clk), .aresetn(aresetn), .v_i(1'b0), .ready_o(ready3),
    .node_id_i(4'd0), .data_not_reset_i(1'b0), .len_i(1'b0), .payload_i(1'b0),
    .tag_data_o(tag3), .init_done_o(init_done3), .busy_o(busy3)
  );

  task automatic check(input string name, input logic obs, input logic exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%b expected=%b at t=%0t", name, obs, exp, $time);
    end
  endtask

  // Bit at position pos of a packet followed by its gap (zero past the packet end).
  function automatic logic pkt_bit(int id, int dnr_v, int len_v, int pl, int pos);
    if (pos == 0) return 1'b1;
    if (pos <= LG_ELS) return ((id >> (pos - 1)) & 1) == 1;
    if (pos == LG_ELS + 1) return dnr_v == 1;
    if (pos == LG_ELS + 2) return (len_v & 1) == 1;
    if (pos < LG_ELS + 3 + len_v) return ((pl >> (pos - LG_ELS - 3)) & 1) == 1;
    return 1'b0;
  endfunction

  // Entered with reset just released; j counts cycles after the first active edge.
  task automatic init_sweep();
    for (int j = 0; j <= 480; j++) begin
      @(posedge clk); #1;
      if (j < 160) begin
        check("init_bit", tag, pkt_bit(j / 10, 0, 1, 0, j % 10));
        check("init_done_low", init_done, 1'b0);
        check("init_busy", busy, 1'b1);
        check("init_ready_low", ready, 1'b0);
      end else if (j == 160) begin
        check("init_done_rise", init_done, 1'b1);
        check("init_ready_rise", ready, 1'b1);
        check("init_idle_busy", busy, 1'b0);
      end
      if (j < 480) begin
        check("div3_bit", tag3, pkt_bit(j / 30, 0, 1, 0, (j % 30) / 3));
        check("div3_init_low", init_done3, 1'b0);
      end else begin
        check("div3_init_rise", init_done3, 1'b1);
        check("div3_ready", ready3, 1'b1);
      end
    end
    $display("init sweep complete at t=%0t", $time);
  endtask

  task automatic run_pkt(input int id, input int dnr_v, input int len_v, input int pl, input bit hold);
    int n;
    n = 7 + len_v;
    @(posedge clk); #1;
    check("idle_ready", ready, 1'b1);
    check("idle_tag", tag, 1'b0);
    check("idle_busy", busy, 1'b0);
    v_i = 1'b1;
    node_id = 4'(id);
    dnr = 1'(dnr_v);
    len = 1'(len_v);
    payload = 1'(pl);
    $display("pkt id=%0d dnr=%0d len=%0d payload=%0d hold=%0d", id, dnr_v, len_v, pl, hold);
    for (int j = 0; j < n + 2; j++) begin
      @(posedge clk); #1;
      check("pkt_bit", tag, pkt_bit(id, dnr_v, len_v, pl, j));
      check("pkt_busy", busy, 1'b1);
      check("pkt_ready_low", ready, 1'b0);
      v_i = hold;
      node_id = 4'($urandom);
      dnr = 1'($urandom);
      len = 1'($urandom);
      payload = 1'($urandom);
    end
  endtask

  initial begin
    aresetn = 1'b0;
    v_i = 1'b0;
    node_id = '0;
    dnr = 1'b0;
    len = '0;
    payload = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_tag", tag, 1'b0);
    check("rst_ready", ready, 1'b0);
    check("rst_init_done", init_done, 1'b0);
    check("rst_busy", busy, 1'b1);
    check("rst_tag3", tag3, 1'b0);
    check("rst_busy3", busy3, 1'b1);
    aresetn = 1'b1;
    init_sweep();

    run_pkt(3, 1, 1, 1, 1'b0);
    run_pkt(15, 1, 0, 0, 1'b0);

    for (int i = 0; i < 20; i++)
      run_pkt($urandom_range(0, 15), $urandom_range(0, 1), $urandom_range(0, 1),
              $urandom_range(0, 1), 1'b0);

    for (int i = 0; i < 6; i++)
      run_pkt($urandom_range(0, 15), $urandom_range(0, 1), $urandom_range(0, 1),
              $urandom_range(0, 1), i < 5);

    // Reset during the ID field of a packet in flight.
    @(posedge clk); #1;
    v_i = 1'b1;
    node_id = 4'd5;
    dnr = 1'b1;
    len = 1'b1;
    payload = 1'b1;
    @(posedge clk); #1;
    v_i = 1'b0;
    check("mid_start", tag, 1'b1);
    @(posedge clk); #1;
    check("mid_id0", tag, 1'b1);
    aresetn = 1'b0;
    @(posedge clk); #1;
    check("mid_rst_tag", tag, 1'b0);
    check("mid_rst_busy", busy, 1'b1);
    check("mid_rst_ready", ready, 1'b0);
    check("mid_rst_init_done", init_done, 1'b0);
    check("mid_rst_init_done3", init_done3, 1'b0);
    @(posedge clk); #1;
    aresetn = 1'b1;
    init_sweep();
    run_pkt(9, 0, 1, 1, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
